// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared constants for the instruction-memory loader and the core that
// fetches from the same store: memory geometry, the NOP encoding written
// into the unused tail, and the loader state encoding.
package imem_loader_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    // One extra bit so the count can reach DEPTH without wrapping.
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [DATA_W-1:0] NOP = 8'h00;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        FILL = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } state_t;

endpackage

// File: rtl/imem_loader.sv
// imem_loader
// Streams a framed program image (LEN, N instruction bytes, CSUM) into the
// 32 x 8-bit instruction store, pads the rest of the store with NOPs and
// holds the core stalled until a checksum-verified image is in place.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   load_start           pulse that opens a load frame (IDLE/DONE/ERR only)
//   in_valid, in_data    byte stream source
//   in_ready             loader can take a byte (LEN, DATA, CSUM)
//   wr_en/addr/data      instruction memory write port (registered)
//   core_hold            keeps the core stalled while high
//   done, err            load verified / frame rejected (levels)
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | after reset, waiting for load_start
// LEN   | waiting for the length byte N (legal 1..DEPTH)
// DATA  | writing N instruction bytes to addresses 0..N-1
// CSUM  | comparing the checksum byte against the running sum
// FILL  | writing NOPs to addresses N..DEPTH-1, one per cycle
// DONE  | image valid, core released; load_start reloads
// ERR   | frame rejected, core kept stalled; load_start reloads
module imem_loader
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              core_hold,
    output logic              done,
    output logic              err
);

    localparam logic [DATA_W-1:0] MAX_LEN   = DATA_W'(DEPTH);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  LAST_ADDR = CNT_W'(DEPTH - 1);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [CNT_W-1:0]  len_q, len_nx;
    logic [DATA_W-1:0] csum, csum_nx;
    logic              wr_en_nx;
    logic [ADDR_W-1:0] wr_addr_nx;
    logic [DATA_W-1:0] wr_data_nx;
    logic              hold_nx, done_nx, err_nx;
    logic              accept;

    assign in_ready = (state == LEN) || (state == DATA) || (state == CSUM);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        len_nx     = len_q;
        csum_nx    = csum;
        wr_en_nx   = 1'b0;
        wr_addr_nx = wr_addr;
        wr_data_nx = wr_data;
        hold_nx    = core_hold;
        done_nx    = done;
        err_nx     = err;

        case (state)
            IDLE: begin
                if (load_start) begin
                    state_nx = LEN;
                    hold_nx  = 1'b1;
                    done_nx  = 1'b0;
                    err_nx   = 1'b0;
                end
            end
            LEN: begin
                if (accept) begin
                    if (in_data == '0 || in_data > MAX_LEN) begin
                        state_nx = ERR;
                    end else begin
                        len_nx   = in_data[CNT_W-1:0];
                        cnt_nx   = '0;
                        csum_nx  = '0;
                        state_nx = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    wr_en_nx   = 1'b1;
                    wr_addr_nx = cnt[ADDR_W-1:0];
                    wr_data_nx = in_data;
                    csum_nx    = csum + in_data;
                    cnt_nx     = cnt + 1'b1;
                    if (cnt + 1'b1 == len_q)
                        state_nx = CSUM;
                end
            end
            CSUM: begin
                if (accept) begin
                    if (in_data != csum)
                        state_nx = ERR;
                    else if (len_q < DEPTH_C)
                        state_nx = FILL;
                    else
                        state_nx = DONE;
                end
            end
            FILL: begin
                // cnt already equals N on entry, so fill starts right after the image.
                wr_en_nx   = 1'b1;
                wr_addr_nx = cnt[ADDR_W-1:0];
                wr_data_nx = NOP;
                cnt_nx     = cnt + 1'b1;
                if (cnt == LAST_ADDR)
                    state_nx = DONE;
            end
            DONE: begin
                if (load_start) begin
                    state_nx = LEN;
                    hold_nx  = 1'b1;
                    done_nx  = 1'b0;
                    err_nx   = 1'b0;
                end else begin
                    // Released one cycle after the last write strobe.
                    done_nx  = 1'b1;
                    hold_nx  = 1'b0;
                end
            end
            ERR: begin
                if (load_start) begin
                    state_nx = LEN;
                    hold_nx  = 1'b1;
                    done_nx  = 1'b0;
                    err_nx   = 1'b0;
                end else begin
                    err_nx   = 1'b1;
                    hold_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            len_q     <= '0;
            csum      <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            core_hold <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            len_q     <= len_nx;
            csum      <= csum_nx;
            wr_en     <= wr_en_nx;
            wr_addr   <= wr_addr_nx;
            wr_data   <= wr_data_nx;
            core_hold <= hold_nx;
            done      <= done_nx;
            err       <= err_nx;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Table of framed loads with hand-computed outcomes, plus hand-written
// sequences for async reset mid-frame, a full-depth image and load_start
// pulsed mid-frame. Writes are logged and compared to a reference list.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              core_hold;
    logic              done;
    logic              err;

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .core_hold  (core_hold),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t        log_q[$];
    logic [7:0] tx_q[$];

    always @(negedge clk) begin
        if (wr_en === 1'b1)
            log_q.push_back('{int'(wr_addr), int'(wr_data), cyc});
    end

    typedef struct {
        logic [7:0]      len;
        logic [3:0][7:0] d;      // d[0] is sent first
        logic [7:0]      csum;
        bit              gap;
        bit              exp_done;
        bit              exp_err;
        int              exp_nwr;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] len, input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] csum,
                                input bit gap, input bit dn, input bit er, input int nwr);
        vec_t v;
        v.len = len; v.d = {b3, b2, b1, b0}; v.csum = csum; v.gap = gap;
        v.exp_done = dn; v.exp_err = er; v.exp_nwr = nwr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t;
        t = 0;
        if (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=%0d required=<50", t);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] len, input logic [7:0] csum, input bit gap, input bit ls_mid);
        int t;
        log_q.delete();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        send_byte(len, gap);
        if (len != 0 && len <= 32) begin
            foreach (tx_q[i]) begin
                send_byte(tx_q[i], gap);
                if (ls_mid && i == 0) begin
                    load_start = 1'b1;
                    @(negedge clk);
                    load_start = 1'b0;
                end
            end
            send_byte(csum, gap);
        end
        t = 0;
        while (!(done === 1'b1 || err === 1'b1) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            checks++;
            failures++;
            $display("FAIL end_timeout actual=%0d required=<100", t);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic verify(input string name, input int nb, input bit exp_done, input bit exp_err, input int exp_nwr);
        int  n;
        bit  consec;
        check({name, ".done"}, done, exp_done);
        check({name, ".err"}, err, exp_err);
        check({name, ".core_hold"}, core_hold, !exp_done);
        check({name, ".in_ready"}, in_ready, 1'b0);
        check({name, ".nwr"}, log_q.size(), exp_nwr);
        n = (log_q.size() < exp_nwr) ? log_q.size() : exp_nwr;
        for (int i = 0; i < n; i++) begin
            int ed;
            ed = (i < nb) ? int'(tx_q[i]) : 0;
            check($sformatf("%s.wr%0d", name, i), {log_q[i].addr[15:0], log_q[i].data[15:0]},
                  {i[15:0], ed[15:0]});
        end
        if (exp_done && nb < 32 && log_q.size() == exp_nwr) begin
            consec = 1'b1;
            for (int i = nb + 1; i < log_q.size(); i++)
                if (log_q[i].cyc != log_q[i-1].cyc + 1) consec = 1'b0;
            check({name, ".fill_consec"}, consec, 1'b1);
        end
    endtask

    vec_t vecs[8];

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = mk(8'd3,  8'h41, 8'h0A, 8'hC2, 8'h00, 8'h0D, 0, 1, 0, 32);
        vecs[1] = mk(8'd3,  8'h41, 8'h0A, 8'hC2, 8'h00, 8'h0D, 1, 1, 0, 32);
        vecs[2] = mk(8'd2,  8'h10, 8'h20, 8'h00, 8'h00, 8'h31, 0, 0, 1, 2);
        vecs[3] = mk(8'd2,  8'h11, 8'h22, 8'h00, 8'h00, 8'h33, 0, 1, 0, 32);
        vecs[4] = mk(8'd0,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0);
        vecs[5] = mk(8'd33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0);
        vecs[6] = mk(8'd4,  8'hFF, 8'hFF, 8'h01, 8'h02, 8'h01, 1, 1, 0, 32);
        vecs[7] = mk(8'd1,  8'h7E, 8'h00, 8'h00, 8'h00, 8'h7E, 0, 1, 0, 32);

        rst        = 1'b1;
        load_start = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        @(negedge clk);
        check("rst.wr_en", wr_en, 1'b0);
        check("rst.wr_addr", wr_addr, 0);
        check("rst.wr_data", wr_data, 0);
        check("rst.core_hold", core_hold, 1'b1);
        check("rst.done", done, 1'b0);
        check("rst.err", err, 1'b0);
        check("rst.in_ready", in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            int nb;
            tx_q.delete();
            nb = (vecs[v].len == 0 || vecs[v].len > 32) ? 0 : int'(vecs[v].len);
            for (int i = 0; i < nb; i++) tx_q.push_back(vecs[v].d[i]);
            run_frame(vecs[v].len, vecs[v].csum, vecs[v].gap, 1'b0);
            verify($sformatf("vec%0d", v), nb, vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_nwr);
        end

        // Full-depth image: no fill, last address 31.
        tx_q.delete();
        for (int i = 0; i < 32; i++) tx_q.push_back(8'h01);
        run_frame(8'd32, 8'h20, 1'b0, 1'b0);
        verify("full", 32, 1'b1, 1'b0, 32);

        // load_start between data bytes must not restart the frame.
        tx_q = '{8'h41, 8'h0A, 8'hC2};
        run_frame(8'd3, 8'h0D, 1'b0, 1'b1);
        verify("ls_mid", 3, 1'b1, 1'b0, 32);

        // Async reset after two of four data bytes.
        log_q.delete();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        send_byte(8'd4, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        check("mid.wr_en", wr_en, 1'b1);
        check("mid.wr_addr", wr_addr, 1);
        check("mid.wr_data", wr_data, 8'hBB);
        #2 rst = 1'b1;
        #1;
        check("arst.wr_en", wr_en, 1'b0);
        check("arst.wr_addr", wr_addr, 0);
        check("arst.wr_data", wr_data, 0);
        check("arst.core_hold", core_hold, 1'b1);
        check("arst.done", done, 1'b0);
        check("arst.err", err, 1'b0);
        check("arst.in_ready", in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tx_q = '{8'h11, 8'h22};
        run_frame(8'd2, 8'h33, 1'b0, 1'b0);
        verify("after_rst", 2, 1'b1, 1'b0, 32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
